// File: rtl/spi_prog_master.sv
// spi_prog_master
// Host-side master for the tiny processor's serial programming/run link.
// Accepts parallel commands on a valid/ready port, serialises 12-bit
// {data,addr} frames LSB first under csi_n/csd_n, and launches and supervises
// program runs through proc_en/done_in with bounded start and run timeouts.
module spi_prog_master #(
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 4,
  parameter int RUN_TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       csi_n,
  output logic       csd_n,
  output logic       mosi,
  output logic       proc_en,
  input  logic       done_in,
  output logic       run_done,
  output logic       run_err,
  output logic       busy
);

  localparam int GAP_W   = $clog2(GAP_CYCLES) + 1;
  localparam int START_W = $clog2(START_TIMEOUT) + 1;
  localparam int RUN_W   = $clog2(RUN_TIMEOUT) + 1;

  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [START_W-1:0] START_LAST = START_W'(START_TIMEOUT - 1);
  localparam logic [START_W-1:0] START_MAX  = '1;
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(RUN_TIMEOUT - 1);
  localparam logic [RUN_W-1:0]   RUN_MAX    = '1;

  localparam logic [1:0] OP_WR_I = 2'b00;
  localparam logic [1:0] OP_WR_D = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;

  localparam logic [3:0] LAST_BIT = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
    RUN_START,
    RUN_WAIT
  } state_t;

  // Control state (reset)
  state_t             state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [START_W-1:0] start_cnt_q, start_cnt_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic               run_q, run_d;
  logic               csi_n_q, csi_n_d;
  logic               csd_n_q, csd_n_d;
  logic               mosi_q, mosi_d;
  logic               run_done_q, run_done_d;
  logic               run_err_q, run_err_d;

  // Latched operands (no reset; only meaningful while a frame is shifting)
  logic [11:0]        frame_q;
  logic               sel_d_q;
  logic               accept_wr;

  // Next-state and next-output decode for the command/shift/run sequencer
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    start_cnt_d = start_cnt_q;
    run_cnt_d   = run_cnt_q;
    run_d       = run_q;
    csi_n_d     = 1'b1;
    csd_n_d     = 1'b1;
    mosi_d      = 1'b0;
    run_done_d  = 1'b0;
    run_err_d   = 1'b0;
    accept_wr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WR_I, OP_WR_D: begin
              accept_wr = 1'b1;
              state_d   = SHIFT;
              bit_cnt_d = 4'd0;
              csi_n_d   = cmd_op[0];
              csd_n_d   = ~cmd_op[0];
              mosi_d    = cmd_addr[0];
            end
            OP_RUN: begin
              state_d     = RUN_START;
              run_d       = 1'b1;
              start_cnt_d = '0;
            end
            default: begin
              // reserved opcode: consumed without effect
            end
          endcase
        end
      end

      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          // chip select and mosi release together on the edge after bit 11
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          csi_n_d   = sel_d_q;
          csd_n_d   = ~sel_d_q;
          mosi_d    = frame_q[bit_cnt_q + 4'd1];
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      RUN_START: begin
        if (!done_in) begin
          state_d   = RUN_WAIT;
          run_cnt_d = '0;
        end else if (start_cnt_q == START_LAST) begin
          state_d     = IDLE;
          run_d       = 1'b0;
          run_err_d   = 1'b1;
          start_cnt_d = '0;
        end else if (start_cnt_q != START_MAX) begin
          start_cnt_d = start_cnt_q + START_W'(1);
        end
      end

      RUN_WAIT: begin
        if (done_in) begin
          state_d    = IDLE;
          run_d      = 1'b0;
          run_done_d = 1'b1;
          run_cnt_d  = '0;
        end else if (run_cnt_q == RUN_LAST) begin
          state_d   = IDLE;
          run_d     = 1'b0;
          run_err_d = 1'b1;
          run_cnt_d = '0;
        end else if (run_cnt_q != RUN_MAX) begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        run_d   = 1'b0;
      end
    endcase
  end

  // Control and registered-output state; reset abandons any frame or run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      start_cnt_q <= '0;
      run_cnt_q   <= '0;
      run_q       <= 1'b0;
      csi_n_q     <= 1'b1;
      csd_n_q     <= 1'b1;
      mosi_q      <= 1'b0;
      run_done_q  <= 1'b0;
      run_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      start_cnt_q <= start_cnt_d;
      run_cnt_q   <= run_cnt_d;
      run_q       <= run_d;
      csi_n_q     <= csi_n_d;
      csd_n_q     <= csd_n_d;
      mosi_q      <= mosi_d;
      run_done_q  <= run_done_d;
      run_err_q   <= run_err_d;
    end
  end

  // Capture the frame and target cache when a write command is accepted
  always_ff @(posedge clk) begin
    if (accept_wr) begin
      frame_q <= {cmd_data, cmd_addr};
      sel_d_q <= cmd_op[0];
    end
  end

  // Run enable: drops in the same cycle done_in rises so the slave cannot re-enter EXEC
  always_comb begin
    proc_en = 1'b0;
    if (state_q == RUN_START) begin
      proc_en = run_q;
    end else if (state_q == RUN_WAIT) begin
      proc_en = run_q & ~done_in;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign csi_n     = csi_n_q;
  assign csd_n     = csd_n_q;
  assign mosi      = mosi_q;
  assign run_done  = run_done_q;
  assign run_err   = run_err_q;

endmodule

// File: doc/spi_prog_master.md
Name: spi_prog_master

Overview:
- Host-side master for the tiny processor's serial programming and run interface. It is the initiating end of the csi/csd/mosi/en/done link.
- Accepts parallel commands over a valid/ready port and serialises 12-bit {data,addr} frames onto mosi under the chip selects. It also launches program execution and tracks the processor's done line until the run completes or times out.
- Sits in the test harness / companion FPGA and drives the processor's uio_in[3:0]; it observes uio_out[5].

Parameters:
- GAP_CYCLES, 2, idle cycles with both chip selects high after each frame. Must be >= 2 to cover the slave's RECV->WRITE->IDLE sequence.
- START_TIMEOUT, 4, max cycles to wait for done_in to fall after en is raised.
- RUN_TIMEOUT, 1024, max cycles to wait for done_in to rise once the run has started.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  master can accept a command
- cmd_op  in  2  00 = write icache, 01 = write dcache, 10 = run, 11 = reserved (treated as no-op)
- cmd_addr  in  4  target cache address
- cmd_data  in  8  byte to write
- csi_n  out  1  instruction-cache chip select, active low
- csd_n  out  1  data-cache chip select, active low
- mosi  out  1  serial data to processor
- proc_en  out  1  run enable to processor (uio_in[0])
- done_in  in  1  processor done (high = slave idle)
- run_done  out  1  one-cycle pulse: run completed normally
- run_err  out  1  one-cycle pulse: run start or run timeout
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous and active low. On assertion, regardless of current state or mid-frame position:
  - state returns to IDLE
  - csi_n = csd_n = 1, mosi = 0, proc_en = 0
  - run_done = run_err = 0, busy = 0, cmd_ready = 1
  - all counters clear
- A partially shifted frame is simply abandoned; the slave discards it because it never sees a completed write.
- csi_n, csd_n, mosi, run_done, run_err and the internal run_q are registered. proc_en is gated combinationally (see RUN_WAIT).
- cmd_ready = (state == IDLE). A command is accepted when cmd_valid & cmd_ready on a clock edge. Operands are latched on acceptance.
- Frame format: frame[11:0] = {cmd_data, cmd_addr}, transmitted LSB first (frame[0] first, frame[11] last). The slave shifts in at its MSB, so after 12 shifts its buffer holds data in [11:4] and addr in [3:0].
- States:
  - IDLE:
    - op 00/01 accepted -> SHIFT. The selected CS (csi_n for 00, csd_n for 01) goes low on the next edge, with mosi = frame[0].
    - op 10 -> RUN_START with run_q = 1.
    - op 11 -> stays in IDLE.
  - SHIFT:
    - CS held low for exactly 12 consecutive cycles; mosi = frame[bit_cnt], bit_cnt 0..11.
    - After bit 11, CS goes high and mosi goes to 0 on the same edge -> GAP.
    - The non-selected CS stays high throughout. proc_en is always 0 here.
  - GAP: both CS high for GAP_CYCLES cycles, then -> IDLE.
  - RUN_START:
    - proc_en = 1. Wait for done_in == 0, then -> RUN_WAIT.
    - If START_TIMEOUT cycles pass without that, drop run_q, pulse run_err -> IDLE.
  - RUN_WAIT:
    - proc_en = run_q & ~done_in, so en falls in the same cycle done_in rises. This prevents the slave from re-entering EXEC.
    - On done_in == 1: run_q cleared, run_done pulsed -> IDLE.
    - After RUN_TIMEOUT cycles: run_q cleared (slave leaves EXEC next cycle), run_err pulsed -> IDLE.
- CS and proc_en are never active simultaneously, since the slave's write path requires en = 0.
- Timeout counters are width CLOG2 of their parameter plus 1. They saturate and never wrap.
- cmd_valid is ignored while busy. No command is lost, because ready stays low.

Test Plan:
- Reset, then op 00 with addr 0x5, data 0xA3.
  - csi_n low for exactly 12 cycles; mosi sequence 1,0,1,0,1,1,0,0,0,1,0,1.
  - csd_n stays 1; then 2 cycles with both CS high; cmd_ready returns to 1.
  - Paired with the processor model: icache[5] == 0xA3.
- Back-to-back op 01 commands to addr 0xF and addr 0x0, with cmd_valid held high.
  - Second frame begins no earlier than GAP_CYCLES + 1 cycles after the first ends.
  - csi_n stays 1 throughout.
- op 10 with a slave model dropping done for 20 cycles.
  - proc_en high from the cycle after acceptance.
  - proc_en falls in the same cycle done_in rises.
  - run_done pulses once; the slave model never re-enters EXEC.
- op 10 with done_in stuck at 1.
  - run_err pulses after 4 cycles; proc_en returns to 0; cmd_ready returns to 1.
- op 10 with done_in stuck at 0, RUN_TIMEOUT set to 16.
  - run_err pulses at cycle 16 of RUN_WAIT; proc_en goes to 0; no run_done pulse.
- rst_n asserted mid-frame at bit 6.
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, a fresh op 00 frame transmits correctly.
